// File: rtl/fifo_wide_to_narrow.sv
// Wide-to-narrow FWFT FIFO: stores IN_WIDTH-bit words and hands them out as OUT_WIDTH-bit slices.
// A one-word output buffer holds the word being sliced so reads continue across word boundaries without a gap.
module fifo_wide_to_narrow #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int DEPTH     = 4096,
  parameter int LSB_FIRST = 1,
  localparam int RATIO    = IN_WIDTH / OUT_WIDTH,
  localparam int SW       = $clog2(DEPTH * RATIO + RATIO) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 WRITE,
  input  logic [IN_WIDTH-1:0]  DATA_IN,
  output logic                 FULL,
  input  logic                 READ,
  output logic [OUT_WIDTH-1:0] DATA_OUT,
  output logic                 EMPTY,
  output logic [SW-1:0]        SIZE,
  output logic                 OVERFLOW
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SELW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SELW-1:0] LAST_SEL = SELW'(RATIO - 1);

  if (IN_WIDTH % OUT_WIDTH != 0) begin : g_chk_ratio
    $error("fifo_wide_to_narrow: IN_WIDTH must be a multiple of OUT_WIDTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("fifo_wide_to_narrow: DEPTH must be a power of 2 and at least 2");
  end

  logic [IN_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic [IN_WIDTH-1:0] out_buf;
  logic                buf_valid;
  logic [SELW-1:0]     sel;
  logic [SELW-1:0]     slice_idx;
  logic [RATIO-1:0][OUT_WIDTH-1:0] slices;

  logic full;
  logic wr_en;
  logic rd_fire;
  logic last;
  logic load;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign wr_en   = WRITE && !full;
  assign rd_fire = READ && buf_valid;
  assign last    = (sel == LAST_SEL);
  // Refill the buffer as soon as it is empty or its final slice is being consumed.
  assign load    = (count != '0) && (!buf_valid || (rd_fire && last));

  assign FULL  = full;
  assign EMPTY = !buf_valid;
  assign SIZE  = SW'(count) * SW'(RATIO) + (buf_valid ? (SW'(RATIO) - SW'(sel)) : SW'(0));

  // Storage array is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_buf   <= '0;
      buf_valid <= 1'b0;
      sel       <= '0;
      OVERFLOW  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (WRITE && full) begin
        OVERFLOW <= 1'b1;
      end
      if (load) begin
        out_buf   <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        sel       <= '0;
        buf_valid <= 1'b1;
      end else if (rd_fire) begin
        if (last) begin
          buf_valid <= 1'b0;
        end else begin
          sel <= sel + 1'b1;
        end
      end
      if (wr_en && !load) begin
        count <= count + 1'b1;
      end else if (!wr_en && load) begin
        count <= count - 1'b1;
      end
    end
  end

  assign slices = out_buf;

  always_comb begin
    slice_idx = sel;
    if (LSB_FIRST == 0) begin
      slice_idx = LAST_SEL - sel;
    end
  end

  assign DATA_OUT = slices[slice_idx];

endmodule

// File: tb/tb_fifo_wide_to_narrow.sv
// Scoreboard bench for fifo_wide_to_narrow: three instances cover default, MSB-first and shallow (DEPTH=4) builds.
module tb_fifo_wide_to_narrow;

  logic        CLK = 1'b0;
  logic        RST;
  logic        write_s [3];
  logic        read_s  [3];
  logic [31:0] din_s   [3];
  logic [7:0]  dout_s  [3];
  logic        full_s  [3];
  logic        empty_s [3];
  logic        ovf_s   [3];
  logic [15:0] size0;
  logic [7:0]  size1;
  logic [5:0]  size2;

  logic [7:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  fifo_wide_to_narrow #(.IN_WIDTH(32), .OUT_WIDTH(8), .DEPTH(4096), .LSB_FIRST(1)) u_def (
    .CLK(CLK), .RST(RST), .WRITE(write_s[0]), .DATA_IN(din_s[0]), .FULL(full_s[0]), .READ(read_s[0]),
    .DATA_OUT(dout_s[0]), .EMPTY(empty_s[0]), .SIZE(size0), .OVERFLOW(ovf_s[0]));

  fifo_wide_to_narrow #(.IN_WIDTH(32), .OUT_WIDTH(8), .DEPTH(16), .LSB_FIRST(0)) u_msb (
    .CLK(CLK), .RST(RST), .WRITE(write_s[1]), .DATA_IN(din_s[1]), .FULL(full_s[1]), .READ(read_s[1]),
    .DATA_OUT(dout_s[1]), .EMPTY(empty_s[1]), .SIZE(size1), .OVERFLOW(ovf_s[1]));

  fifo_wide_to_narrow #(.IN_WIDTH(32), .OUT_WIDTH(8), .DEPTH(4), .LSB_FIRST(1)) u_d4 (
    .CLK(CLK), .RST(RST), .WRITE(write_s[2]), .DATA_IN(din_s[2]), .FULL(full_s[2]), .READ(read_s[2]),
    .DATA_OUT(dout_s[2]), .EMPTY(empty_s[2]), .SIZE(size2), .OVERFLOW(ovf_s[2]));

  function automatic logic [15:0] get_size(input int k);
    case (k)
      0:       return size0;
      1:       return {8'd0, size1};
      default: return {10'd0, size2};
    endcase
  endfunction

  function automatic logic [31:0] mk_word(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Instance 1 is built MSB-first; the others deliver the low slice first.
  task automatic push_word(input int k, input logic [31:0] w);
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back((k == 1) ? w[8*(3-j) +: 8] : w[8*j +: 8]);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      write_s[k] = 1'b0; read_s[k] = 1'b0; din_s[k] = '0;
    end
    tick(); tick();
    RST = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (empty_s[k] !== 1'b1) begin n_err++; $display("[TB] FAIL reset_empty[%0d]: got %b want 1", k, empty_s[k]); end
      n_cmp++; if (full_s[k] !== 1'b0) begin n_err++; $display("[TB] FAIL reset_full[%0d]: got %b want 0", k, full_s[k]); end
      n_cmp++; if (get_size(k) !== 16'd0) begin n_err++; $display("[TB] FAIL reset_size[%0d]: got %0d want 0", k, get_size(k)); end
      n_cmp++; if (dout_s[k] !== 8'h00) begin n_err++; $display("[TB] FAIL reset_dout[%0d]: got %h want 00", k, dout_s[k]); end
      n_cmp++; if (ovf_s[k] !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ovf[%0d]: got %b want 0", k, ovf_s[k]); end
    end
  endtask

  task automatic test_basic();
    logic [7:0] e;
    din_s[0] = 32'h44332211; write_s[0] = 1'b1; push_word(0, din_s[0]);
    tick();
    write_s[0] = 1'b0;
    n_cmp++; if (empty_s[0] !== 1'b1) begin n_err++; $display("[TB] FAIL basic_latency_empty: got %b want 1", empty_s[0]); end
    tick();
    n_cmp++; if (empty_s[0] !== 1'b0) begin n_err++; $display("[TB] FAIL basic_empty: got %b want 0", empty_s[0]); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_cmp++; if (dout_s[0] !== e) begin n_err++; $display("[TB] FAIL basic_dout[%0d]: got %h want %h", i, dout_s[0], e); end
      n_cmp++; if (get_size(0) !== 16'(4 - i)) begin n_err++; $display("[TB] FAIL basic_size[%0d]: got %0d want %0d", i, get_size(0), 4 - i); end
      read_s[0] = 1'b1;
      tick();
      read_s[0] = 1'b0;
    end
    n_cmp++; if (empty_s[0] !== 1'b1) begin n_err++; $display("[TB] FAIL basic_end_empty: got %b want 1", empty_s[0]); end
    n_cmp++; if (get_size(0) !== 16'd0) begin n_err++; $display("[TB] FAIL basic_end_size: got %0d want 0", get_size(0)); end
  endtask

  task automatic test_msb_first();
    logic [7:0] e;
    din_s[1] = 32'hAABBCCDD; write_s[1] = 1'b1; push_word(1, din_s[1]);
    tick();
    write_s[1] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_cmp++; if (empty_s[1] !== 1'b0) begin n_err++; $display("[TB] FAIL msb_empty[%0d]: got %b want 0", i, empty_s[1]); end
      n_cmp++; if (dout_s[1] !== e) begin n_err++; $display("[TB] FAIL msb_dout[%0d]: got %h want %h", i, dout_s[1], e); end
      read_s[1] = 1'b1;
      tick();
      read_s[1] = 1'b0;
    end
    n_cmp++; if (empty_s[1] !== 1'b1) begin n_err++; $display("[TB] FAIL msb_end_empty: got %b want 1", empty_s[1]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      din_s[0] = mk_word(8'(4 * i)); write_s[0] = 1'b1; push_word(0, din_s[0]);
      tick();
    end
    write_s[0] = 1'b0;
    read_s[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      e = exp_q.pop_front();
      n_cmp++; if (empty_s[0] !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_empty[%0d]: got %b want 0", i, empty_s[0]); end
      n_cmp++; if (dout_s[0] !== e) begin n_err++; $display("[TB] FAIL b2b_dout[%0d]: got %h want %h", i, dout_s[0], e); end
      n_cmp++; if (get_size(0) !== 16'(12 - i)) begin n_err++; $display("[TB] FAIL b2b_size[%0d]: got %0d want %0d", i, get_size(0), 12 - i); end
      tick();
    end
    read_s[0] = 1'b0;
    n_cmp++; if (empty_s[0] !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_end_empty: got %b want 1", empty_s[0]); end
    n_cmp++; if (get_size(0) !== 16'd0) begin n_err++; $display("[TB] FAIL b2b_end_size: got %0d want 0", get_size(0)); end
  endtask

  // Five words fit (four stored plus one in the output buffer); the sixth must be dropped.
  task automatic test_overflow();
    logic [7:0] e;
    for (int i = 0; i < 6; i++) begin
      din_s[2] = mk_word(8'(8'h40 + 4 * i)); write_s[2] = 1'b1;
      if (i < 5) push_word(2, din_s[2]);
      tick();
      n_cmp++; if (full_s[2] !== (i >= 4)) begin n_err++; $display("[TB] FAIL ovf_full[%0d]: got %b want %b", i, full_s[2], i >= 4); end
      n_cmp++; if (ovf_s[2] !== (i >= 5)) begin n_err++; $display("[TB] FAIL ovf_flag[%0d]: got %b want %b", i, ovf_s[2], i >= 5); end
    end
    write_s[2] = 1'b0;
    n_cmp++; if (get_size(2) !== 16'd20) begin n_err++; $display("[TB] FAIL ovf_size: got %0d want 20", get_size(2)); end
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      n_cmp++; if (full_s[2] !== (i < 4)) begin n_err++; $display("[TB] FAIL ovf_drain_full[%0d]: got %b want %b", i, full_s[2], i < 4); end
      n_cmp++; if (dout_s[2] !== e) begin n_err++; $display("[TB] FAIL ovf_drain_dout[%0d]: got %h want %h", i, dout_s[2], e); end
      n_cmp++; if (get_size(2) !== 16'(20 - i)) begin n_err++; $display("[TB] FAIL ovf_drain_size[%0d]: got %0d want %0d", i, get_size(2), 20 - i); end
      if (i == 3) begin
        din_s[2] = 32'hDEADBEEF; write_s[2] = 1'b1;
      end
      read_s[2] = 1'b1;
      tick();
      write_s[2] = 1'b0;
    end
    read_s[2] = 1'b0;
    n_cmp++; if (empty_s[2] !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_end_empty: got %b want 1", empty_s[2]); end
    n_cmp++; if (ovf_s[2] !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_sticky: got %b want 1", ovf_s[2]); end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    int exp_size;
    din_s[2] = mk_word(8'h00); write_s[2] = 1'b1; push_word(2, din_s[2]);
    tick();
    write_s[2] = 1'b0;
    tick();
    exp_size = 4;
    for (int i = 0; i < 48; i++) begin
      write_s[2] = (i % 4 == 0);
      if (write_s[2]) begin
        din_s[2] = mk_word(8'(4 + i)); push_word(2, din_s[2]);
      end
      read_s[2] = 1'b1;
      e = exp_q.pop_front();
      n_cmp++; if (empty_s[2] !== 1'b0) begin n_err++; $display("[TB] FAIL wrap_empty[%0d]: got %b want 0", i, empty_s[2]); end
      n_cmp++; if (dout_s[2] !== e) begin n_err++; $display("[TB] FAIL wrap_dout[%0d]: got %h want %h", i, dout_s[2], e); end
      n_cmp++; if (get_size(2) !== 16'(exp_size)) begin n_err++; $display("[TB] FAIL wrap_size[%0d]: got %0d want %0d", i, get_size(2), exp_size); end
      tick();
      exp_size = exp_size - 1 + (write_s[2] ? 4 : 0);
    end
    write_s[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_cmp++; if (dout_s[2] !== e) begin n_err++; $display("[TB] FAIL wrap_tail_dout[%0d]: got %h want %h", i, dout_s[2], e); end
      n_cmp++; if (get_size(2) !== 16'(exp_size)) begin n_err++; $display("[TB] FAIL wrap_tail_size[%0d]: got %0d want %0d", i, get_size(2), exp_size); end
      tick();
      exp_size--;
    end
    read_s[2] = 1'b0;
    n_cmp++; if (empty_s[2] !== 1'b1) begin n_err++; $display("[TB] FAIL wrap_end_empty: got %b want 1", empty_s[2]); end
    n_cmp++; if (get_size(2) !== 16'd0) begin n_err++; $display("[TB] FAIL wrap_end_size: got %0d want 0", get_size(2)); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    n_cmp++; if (ovf_s[2] !== 1'b1) begin n_err++; $display("[TB] FAIL mid_pre_ovf: got %b want 1", ovf_s[2]); end
    for (int i = 0; i < 2; i++) begin
      din_s[2] = mk_word(8'(8'h80 + 16 * i)); write_s[2] = 1'b1; push_word(2, din_s[2]);
      tick();
    end
    write_s[2] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_cmp++; if (dout_s[2] !== e) begin n_err++; $display("[TB] FAIL mid_dout[%0d]: got %h want %h", i, dout_s[2], e); end
      read_s[2] = 1'b1;
      tick();
      read_s[2] = 1'b0;
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_q.delete();
    n_cmp++; if (empty_s[2] !== 1'b1) begin n_err++; $display("[TB] FAIL mid_rst_empty: got %b want 1", empty_s[2]); end
    n_cmp++; if (get_size(2) !== 16'd0) begin n_err++; $display("[TB] FAIL mid_rst_size: got %0d want 0", get_size(2)); end
    n_cmp++; if (ovf_s[2] !== 1'b0) begin n_err++; $display("[TB] FAIL mid_rst_ovf: got %b want 0", ovf_s[2]); end
    n_cmp++; if (full_s[2] !== 1'b0) begin n_err++; $display("[TB] FAIL mid_rst_full: got %b want 0", full_s[2]); end
    din_s[2] = mk_word(8'hA0); write_s[2] = 1'b1; push_word(2, din_s[2]);
    tick();
    write_s[2] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_cmp++; if (dout_s[2] !== e) begin n_err++; $display("[TB] FAIL mid_new_dout[%0d]: got %h want %h", i, dout_s[2], e); end
      read_s[2] = 1'b1;
      tick();
      read_s[2] = 1'b0;
    end
    n_cmp++; if (empty_s[2] !== 1'b1) begin n_err++; $display("[TB] FAIL mid_end_empty: got %b want 1", empty_s[2]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb_first();
    test_back_to_back();
    test_overflow();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
